// File: rtl/long_mul_unit.sv
// Iterative 32x32 -> 64 multiplier for MUL/UMULL/SMULL with register-file write-back controls.
// Radix-2 shift-add over 32 CALC steps; one extra CALC cycle before DONE, so the completion pulse lands 33 edges after acceptance.
module long_mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         rdlo,
   input  logic [3:0]         rdhi,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               we3,
   output logic               we4,
   output logic [3:0]         wa3,
   output logic [3:0]         wa4
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULL = 2'b01;
   localparam logic [1:0] OP_SMULL = 2'b10;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [3:0]         rdlo_q, rdlo_d;
   logic [3:0]         rdhi_q, rdhi_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               last_q, last_d;
   logic               sign_q, sign_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [3:0]         wa3_q, wa3_d;
   logic [3:0]         wa4_q, wa4_d;

   logic [WIDTH-1:0]   neg_a, neg_b, a_sel, b_sel;
   logic               is_smull;

   // For SMULL the magnitudes are multiplied unsigned; 0x80000000 negates to itself and stays exact.
   assign neg_a    = {WIDTH{1'b0}} - a;
   assign neg_b    = {WIDTH{1'b0}} - b;
   assign is_smull = (op == OP_SMULL);
   assign a_sel    = (is_smull && a[WIDTH-1]) ? neg_a : a;
   assign b_sel    = (is_smull && b[WIDTH-1]) ? neg_b : b;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rdlo_d   = rdlo_q;
      rdhi_d   = rdhi_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      sign_d   = sign_q;
      result_d = result_q;
      wa3_d    = wa3_q;
      wa4_d    = wa4_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CALC;
               op_d     = op;
               rdlo_d   = rdlo;
               rdhi_d   = rdhi;
               mcand_d  = {{WIDTH{1'b0}}, a_sel};
               mplier_d = b_sel;
               sign_d   = is_smull & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               last_d   = 1'b0;
            end
         end
         CALC: begin
            // Write-back addresses move only at completion so they stay valid for the previous result.
            if (last_q) begin
               state_d  = DONE;
               result_d = sign_q ? ({2*WIDTH{1'b0}} - acc_q) : acc_q;
               wa3_d    = rdlo_q;
               wa4_d    = rdhi_q;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
               mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
               cnt_d    = cnt_q + 5'd1;
               last_d   = (cnt_q == 5'd31);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rdlo_q   <= '0;
         rdhi_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         last_q   <= 1'b0;
         sign_q   <= 1'b0;
         result_q <= '0;
         wa3_q    <= '0;
         wa4_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rdlo_q   <= rdlo_d;
         rdhi_q   <= rdhi_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         wa3_q    <= wa3_d;
         wa4_q    <= wa4_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign we3    = done && (op_q == OP_MUL);
   assign we4    = done && ((op_q == OP_UMULL) || (op_q == OP_SMULL));
   assign result = result_q;
   assign wa3    = wa3_q;
   assign wa4    = wa4_q;

endmodule

// File: tb/tb_long_mul_unit.sv
// Directed self-checking bench for long_mul_unit: latency, op variants, busy/start interaction and async reset.
module tb_long_mul_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  rdlo;
   logic [3:0]  rdhi;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        we3;
   logic        we4;
   logic [3:0]  wa3;
   logic [3:0]  wa4;

   int errors = 0;
   int checks = 0;
   int doneCount;

   long_mul_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .rdlo   (rdlo),
      .rdhi   (rdhi),
      .busy   (busy),
      .done   (done),
      .result (result),
      .we3    (we3),
      .we4    (we4),
      .wa3    (wa3),
      .wa4    (wa4)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issues one request accepted at the next edge (N), scrambles the inputs afterwards, optionally pulses a
   // second start while busy, and checks the completion cycle after edge N+33.
   task automatic applyStimulus(input logic [1:0] vOp, input logic [31:0] vA, input logic [31:0] vB,
                                input logic [3:0] vLo, input logic [3:0] vHi, input logic [63:0] expResult,
                                input logic expWe3, input logic expWe4, input int pulseCycle);
      start = 1'b1;
      op    = vOp;
      a     = vA;
      b     = vB;
      rdlo  = vLo;
      rdhi  = vHi;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = ~vOp;
      a     = 32'hDEAD_BEEF;
      b     = 32'h1357_9BDF;
      rdlo  = ~vLo;
      rdhi  = ~vHi;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         if (i == pulseCycle) begin
            start = 1'b1;
            a     = 32'd9;
            b     = 32'd9;
         end else begin
            start = 1'b0;
         end
      end
      checkOutput("done_early", 64'(done), 64'd0);
      checkOutput("busy_calc", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("done_pulse", 64'(done), 64'd1);
      checkOutput("result", result, expResult);
      checkOutput("we3", 64'(we3), 64'(expWe3));
      checkOutput("we4", 64'(we4), 64'(expWe4));
      checkOutput("wa3", 64'(wa3), 64'(vLo));
      checkOutput("wa4", 64'(wa4), 64'(vHi));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      rdlo  = '0;
      rdhi  = '0;

      // Reset asserted before any clock edge must clear outputs immediately.
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_result", result, 64'd0);
      checkOutput("rst_we", 64'({we3, we4}), 64'd0);
      checkOutput("rst_wa", 64'({wa3, wa4}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // UMULL max * max.
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 4'd3, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, -1);
      @(posedge clk);
      #1;
      checkOutput("we4_one_cycle", 64'(we4), 64'd0);
      checkOutput("busy_after_done", 64'(busy), 64'd0);

      // SMULL with negative operands.
      applyStimulus(2'b10, 32'hFFFF_FFFE, 32'd3, 4'd1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b1, -1);
      @(posedge clk);
      #1;
      applyStimulus(2'b10, 32'h8000_0000, 32'h8000_0000, 4'd6, 4'd7, 64'h4000_0000_0000_0000, 1'b0, 1'b1, -1);
      @(posedge clk);
      #1;

      // MUL 7*6 writes only the low word.
      applyStimulus(2'b00, 32'd7, 32'd6, 4'd5, 4'd9, 64'h0000_0000_0000_002A, 1'b1, 1'b0, -1);
      @(posedge clk);
      #1;
      checkOutput("we3_one_cycle", 64'(we3), 64'd0);

      // Start pulsed at CALC cycle 10 must be ignored.
      applyStimulus(2'b01, 32'd3, 32'd4, 4'd8, 4'd10, 64'd12, 1'b0, 1'b1, 10);
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) doneCount++;
      end
      checkOutput("no_second_done", 64'(doneCount), 64'd0);
      checkOutput("result_hold", result, 64'd12);

      // Reserved op: product computed, no write enables; start held through the DONE cycle.
      applyStimulus(2'b11, 32'd2, 32'd3, 4'd4, 4'd6, 64'd6, 1'b0, 1'b0, -1);
      start = 1'b1;
      op    = 2'b01;
      a     = 32'd10;
      b     = 32'd10;
      rdlo  = 4'd1;
      rdhi  = 4'd7;
      @(posedge clk);
      #1;
      checkOutput("op11_busy_low", 64'(busy), 64'd0);
      checkOutput("op11_done_low", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_busy", 64'(busy), 64'd1);
      checkOutput("wa3_hold", 64'(wa3), 64'd4);
      checkOutput("result_hold_b2b", result, 64'd6);
      repeat (32) @(posedge clk);
      #1;
      checkOutput("b2b_not_in_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("b2b_done", 64'(done), 64'd1);
      checkOutput("b2b_result", result, 64'd100);
      checkOutput("b2b_wa3", 64'(wa3), 64'd1);
      @(posedge clk);
      #1;

      // Reset in the middle of CALC aborts with no completion.
      start = 1'b1;
      op    = 2'b01;
      a     = 32'h0000_1234;
      b     = 32'h0000_5678;
      rdlo  = 4'd11;
      rdhi  = 4'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_result", result, 64'd0);
      checkOutput("abort_wa", 64'({wa3, wa4}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || we3 || we4) doneCount++;
      end
      checkOutput("abort_no_done", 64'(doneCount), 64'd0);
      applyStimulus(2'b01, 32'd5, 32'd5, 4'd13, 4'd14, 64'd25, 1'b0, 1'b1, -1);
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so a stuck design cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
